// File: rtl/draw_sequencer.sv
// Sequences a full-screen fill followed by a shape draw, muxing the active
// stage's plot requests onto a registered, clipped VGA plot port.
module draw_sequencer #(
  parameter logic [2:0] FILL_COLOUR   = 3'b000,
  parameter int         PHASE_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic        fs_start,
  output logic [2:0]  fs_colour,
  input  logic        fs_done,
  input  logic [7:0]  fs_x,
  input  logic [6:0]  fs_y,
  input  logic [2:0]  fs_col,
  input  logic        fs_plot,
  output logic        sh_start,
  input  logic        sh_done,
  input  logic [7:0]  sh_x,
  input  logic [6:0]  sh_y,
  input  logic [2:0]  sh_col,
  input  logic        sh_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] plot_count
);

  localparam int               TMR_W    = $clog2(PHASE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PHASE_TIMEOUT - 1);
  localparam logic [14:0]      CNT_MAX  = 15'h7FFF;

  typedef enum logic [2:0] {IDLE, FILL, FILL_REL, SHAPE, FIN, ERR} state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [14:0]       plot_count_q, plot_count_d;
  logic [7:0]        vga_x_q, vga_x_d;
  logic [6:0]        vga_y_q, vga_y_d;
  logic [2:0]        vga_colour_q, vga_colour_d;
  logic              vga_plot_q, vga_plot_d;
  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic [2:0]        sel_col;
  logic              sel_plot;
  logic              timeout;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    plot_count_d = plot_count_q;
    sel_x        = fs_x;
    sel_y        = fs_y;
    sel_col      = fs_col;
    sel_plot     = 1'b0;
    timeout      = (timer_q == TMR_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FILL;
          timer_d      = '0;
          plot_count_d = '0;
        end
      end
      FILL: begin
        sel_plot = fs_plot;
        // fs_done takes priority over a coincident timeout
        if (fs_done) begin
          state_d = FILL_REL;
          timer_d = '0;
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FILL_REL: begin
        state_d = SHAPE;
        timer_d = '0;
      end
      SHAPE: begin
        sel_x    = sh_x;
        sel_y    = sh_y;
        sel_col  = sh_col;
        sel_plot = sh_plot;
        if (sh_done) begin
          state_d = FIN;
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FIN, ERR: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Off-screen requests still latch coordinates but never plot; a plot
    // sampled on the edge into ERR is suppressed so ERR shows vga_plot=0.
    vga_x_d      = sel_x;
    vga_y_d      = sel_y;
    vga_colour_d = sel_col;
    vga_plot_d   = sel_plot && (sel_x <= 8'd159) && (sel_y <= 7'd119) &&
                   (state_d != ERR);

    if (vga_plot_d && (plot_count_q != CNT_MAX)) begin
      plot_count_d = plot_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      plot_count_q <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      plot_count_q <= plot_count_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign fs_start   = (state_q == FILL);
  assign sh_start   = (state_q == SHAPE);
  assign done       = (state_q == FIN) || (state_q == ERR);
  assign err        = (state_q == ERR);
  assign fs_colour  = FILL_COLOUR;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign plot_count = plot_count_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: full run, clipping, inactive-source
// isolation, start drop, phase timeout and asynchronous reset mid-run.
module tb_draw_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done, err;
  logic        fs_start, sh_start;
  logic [2:0]  fs_colour;
  logic        fs_done, sh_done;
  logic [7:0]  fs_x, sh_x;
  logic [6:0]  fs_y, sh_y;
  logic [2:0]  fs_col, sh_col;
  logic        fs_plot, sh_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [14:0] plot_count;

  int n_checks = 0;
  int n_errors = 0;
  int mon_plots = 0;
  int overlap_cycles = 0;
  int sh_cycles = 0;
  int base_plots, base_sh;

  draw_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .err(err),
    .fs_start(fs_start), .fs_colour(fs_colour), .fs_done(fs_done),
    .fs_x(fs_x), .fs_y(fs_y), .fs_col(fs_col), .fs_plot(fs_plot),
    .sh_start(sh_start), .sh_done(sh_done),
    .sh_x(sh_x), .sh_y(sh_y), .sh_col(sh_col), .sh_plot(sh_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .plot_count(plot_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vga_plot === 1'b1) mon_plots++;
    if (fs_start === 1'b1 && sh_start === 1'b1) overlap_cycles++;
    if (sh_start === 1'b1) sh_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    fs_done = 1'b0; fs_x = '0; fs_y = '0; fs_col = '0; fs_plot = 1'b0;
    sh_done = 1'b0; sh_x = '0; sh_y = '0; sh_col = '0; sh_plot = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fs_start", fs_start, 0);
    chk("rst_sh_start", sh_start, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_plot_count", plot_count, 0);

    // Full run: start accepted on the first edge after reset release
    base_plots = mon_plots;
    rst = 1'b0; start = 1'b1;
    step();
    chk("full_fs_start", fs_start, 1);
    chk("full_fs_colour", fs_colour, 0);
    chk("full_sh_start_in_fill", sh_start, 0);
    for (int i = 0; i < 19200; i++) begin
      fs_x = 8'(i % 160); fs_y = 7'(i / 160); fs_col = 3'(i); fs_plot = 1'b1;
      step();
    end
    fs_plot = 1'b0; fs_done = 1'b1;
    step();
    chk("gap_fs_start", fs_start, 0);
    chk("gap_sh_start", sh_start, 0);
    chk("fill_plot_count", plot_count, 19200);
    fs_done = 1'b0;
    step();
    chk("shape_sh_start", sh_start, 1);
    chk("shape_fs_start", fs_start, 0);
    for (int i = 0; i < 500; i++) begin
      sh_x = 8'(i % 160); sh_y = 7'(i / 160); sh_col = 3'(i + 1); sh_plot = 1'b1;
      step();
    end
    sh_plot = 1'b0; sh_done = 1'b1;
    step();
    sh_done = 1'b0;
    chk("full_done", done, 1);
    chk("full_err", err, 0);
    chk("full_sh_start_fin", sh_start, 0);
    chk("full_plot_count", plot_count, 19700);
    chk("full_vga_pulses", mon_plots - base_plots, 19700);
    start = 1'b0;
    step();
    chk("idle_done", done, 0);
    chk("idle_count_hold", plot_count, 19700);

    // Clipping, with fs_plot active while SHAPE runs
    start = 1'b1;
    step();
    chk("clip_count_cleared", plot_count, 0);
    fs_done = 1'b1;
    step();
    fs_done = 1'b0;
    step();
    fs_x = 8'd5; fs_y = 7'd5; fs_plot = 1'b1;
    sh_x = 8'd160; sh_y = 7'd10; sh_col = 3'd1; sh_plot = 1'b1;
    step();
    chk("clip_x_plot", vga_plot, 0);
    chk("clip_x_reg", vga_x, 160);
    sh_x = 8'd10; sh_y = 7'd120;
    step();
    chk("clip_y_plot", vga_plot, 0);
    chk("clip_y_reg", vga_y, 120);
    chk("clip_count", plot_count, 0);
    sh_x = 8'd159; sh_y = 7'd119; sh_col = 3'd5;
    chk("corner_before_edge", vga_plot, 0);
    step();
    chk("corner_plot", vga_plot, 1);
    chk("corner_x", vga_x, 159);
    chk("corner_y", vga_y, 119);
    chk("corner_colour", vga_colour, 5);
    chk("corner_count", plot_count, 1);
    sh_plot = 1'b0;
    step();
    step();
    chk("inactive_fs_plot", vga_plot, 0);
    chk("inactive_fs_count", plot_count, 1);
    fs_plot = 1'b0; sh_done = 1'b1;
    step();
    sh_done = 1'b0;
    chk("clip_done", done, 1);
    chk("clip_final_count", plot_count, 1);
    start = 1'b0;
    step();

    // start dropped mid-FILL, sh_plot active while FILL runs
    start = 1'b1;
    step();
    start = 1'b0;
    sh_x = 8'd20; sh_y = 7'd20; sh_plot = 1'b1;
    step();
    chk("drop_still_fill", fs_start, 1);
    chk("inactive_sh_plot", vga_plot, 0);
    step();
    step();
    chk("inactive_sh_count", plot_count, 0);
    sh_plot = 1'b0; fs_done = 1'b1;
    step();
    fs_done = 1'b0;
    step();
    chk("drop_shape", sh_start, 1);
    sh_done = 1'b1;
    step();
    sh_done = 1'b0;
    chk("drop_done_pulse", done, 1);
    step();
    chk("drop_done_clear", done, 0);
    chk("drop_idle_fs_start", fs_start, 0);
    step();
    chk("drop_stays_idle", fs_start, 0);

    // FILL timeout
    base_sh = sh_cycles;
    start = 1'b1;
    step();
    fs_x = 8'd1; fs_y = 7'd1; fs_plot = 1'b1;
    repeat (19999) step();
    chk("to_err_early", err, 0);
    chk("to_fs_start_early", fs_start, 1);
    step();
    chk("to_err", err, 1);
    chk("to_done", done, 1);
    chk("to_fs_start", fs_start, 0);
    chk("to_sh_start", sh_start, 0);
    chk("to_vga_plot", vga_plot, 0);
    chk("to_sh_never", sh_cycles - base_sh, 0);
    fs_plot = 1'b0; start = 1'b0;
    step();
    chk("to_idle_err", err, 0);
    chk("to_idle_done", done, 0);

    // Asynchronous reset mid-SHAPE
    start = 1'b1;
    step();
    fs_done = 1'b1;
    step();
    fs_done = 1'b0;
    step();
    sh_x = 8'd30; sh_y = 7'd40; sh_col = 3'd3; sh_plot = 1'b1;
    step();
    chk("pre_rst_plot", vga_plot, 1);
    chk("pre_rst_count", plot_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sh_start", sh_start, 0);
    chk("arst_vga_plot", vga_plot, 0);
    chk("arst_vga_x", vga_x, 0);
    chk("arst_count", plot_count, 0);
    chk("arst_done", done, 0);
    sh_plot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_fs_start", fs_start, 1);
    chk("post_rst_count", plot_count, 0);
    fs_done = 1'b1;
    step();
    fs_done = 1'b0;
    step();
    sh_done = 1'b1;
    step();
    sh_done = 1'b0;
    chk("post_rst_done", done, 1);
    chk("post_rst_final_count", plot_count, 0);
    start = 1'b0;
    step();

    chk("start_overlap", overlap_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
